item_dispense_ctrl: RTL and testbench

- Sequential, parametrised successor to the combinational item dispenser in the vending machine datapath.
- Tracks per-item stock and arbitrates one purchase at a time against the current balance.
- Drives a dispense handshake toward the output mechanism and reports the charged cost back to the balance/change logic.
- Adds sold-out tracking, restocking, a dispense timeout, and reject/fault reporting.

---
 rtl/item_dispense_ctrl_pkg.sv | 12 +
 rtl/item_dispense_ctrl_stock_counter.sv | 21 ++
 rtl/item_dispense_ctrl.sv | 100 ++++++++++
 tb/tb_item_dispense_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/item_dispense_ctrl_pkg.sv
// item_dispense_ctrl_pkg: shared FSM encodings and default vending constants
package item_dispense_ctrl_pkg;
  localparam int DEF_NUM_ITEMS = 4;
  localparam int DEF_BAL_W = 32;
  localparam logic [DEF_BAL_W-1:0] PRICE_400 = 32'd400;
  localparam logic [DEF_BAL_W-1:0] PRICE_500 = 32'd500;
  localparam logic [DEF_BAL_W-1:0] PRICE_1000 = 32'd1000;
  localparam logic [DEF_BAL_W-1:0] PRICE_2000 = 32'd2000;
  localparam logic [DEF_NUM_ITEMS*DEF_BAL_W-1:0] DEF_PRICE_TABLE =
    {PRICE_2000, PRICE_1000, PRICE_500, PRICE_400};
  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_e;
endpackage

// File: rtl/item_dispense_ctrl_stock_counter.sv
// item_dispense_ctrl_stock_counter: per-slot stock with reset load, decrement and saturating restock
module item_dispense_ctrl_stock_counter #(
  parameter int STOCK_W = 4,
  parameter int INIT = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [STOCK_W-1:0] count_o,
  output logic               sold_out_o
);
  logic [STOCK_W-1:0] count_q, count_d;
  always_comb
    count_d = (inc_i && !dec_i && count_q != '1) ? count_q + 1'b1 :
              (dec_i && !inc_i && count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk)
    count_q <= !reset_n ? STOCK_W'(INIT) : count_d;
  assign count_o = count_q;
  assign sold_out_o = count_q == '0;
endmodule

// File: rtl/item_dispense_ctrl.sv
// item_dispense_ctrl: one-at-a-time item purchase arbitration with stock tracking and dispense handshake
module item_dispense_ctrl
  import item_dispense_ctrl_pkg::*;
#(
  parameter int NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int BAL_W = DEF_BAL_W,
  parameter int STOCK_W = 4,
  parameter logic [NUM_ITEMS*BAL_W-1:0] PRICE_TABLE = DEF_PRICE_TABLE,
  parameter int INIT_STOCK = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic [BAL_W-1:0]     balance,
  input  logic [NUM_ITEMS-1:0] i_restock_item,
  input  logic                 i_restock_en,
  input  logic                 i_dispense_ack,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic [NUM_ITEMS-1:0] o_sold_out,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [BAL_W-1:0]     item_cost,
  output logic                 o_cost_valid,
  output logic                 o_reject,
  output logic                 o_fault,
  output logic                 o_busy
);
  localparam int IDX_W = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_e               state_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TW-1:0]        timer_q;
  logic [NUM_ITEMS-1:0] out_q, elig, inc, dec;
  logic [BAL_W-1:0]     cost_q;
  logic                 cv_q, rej_q, fault_q;
  logic [STOCK_W-1:0]   stock [NUM_ITEMS];
  logic [BAL_W-1:0]     price [NUM_ITEMS];
  assign inc = i_restock_en ? i_restock_item : '0;
  assign dec = (state_q == S_DISPENSE && i_dispense_ack) ? out_q : '0;
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
    assign price[i] = PRICE_TABLE[i*BAL_W +: BAL_W];
    assign o_available_item[i] = !o_sold_out[i] && price[i] <= balance;
    item_dispense_ctrl_stock_counter #(.STOCK_W(STOCK_W), .INIT(INIT_STOCK)) u_stock (
      .clk(clk), .reset_n(reset_n), .inc_i(inc[i]), .dec_i(dec[i]),
      .count_o(stock[i]), .sold_out_o(o_sold_out[i])
    );
  end
  assign elig = i_select_item & o_available_item;
  always_comb begin
    idx_d = '0;
    for (int k = NUM_ITEMS - 1; k >= 0; k--) idx_d = elig[k] ? IDX_W'(k) : idx_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      timer_q <= '0;
      out_q <= '0;
      cost_q <= '0;
      cv_q <= 1'b0;
      rej_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cost_q <= '0;
      cv_q <= 1'b0;
      rej_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (|i_select_item) begin
            if (elig == '0) rej_q <= 1'b1;
            else begin
              idx_q <= idx_d;
              out_q <= NUM_ITEMS'(1) << idx_d;
              timer_q <= '0;
              state_q <= S_DISPENSE;
            end
          end
        S_DISPENSE:
          if (i_dispense_ack) begin
            out_q <= '0;
            cv_q <= 1'b1;
            cost_q <= price[idx_q];
            state_q <= S_DONE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            out_q <= '0;
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else timer_q <= timer_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_output_item = out_q;
  assign item_cost = cost_q;
  assign o_cost_valid = cv_q;
  assign o_reject = rej_q;
  assign o_fault = fault_q;
  assign o_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_item_dispense_ctrl.sv
// tb_item_dispense_ctrl: directed stimulus against a transaction-level model, checked every cycle
module tb_item_dispense_ctrl;
  localparam int N = 4;
  localparam int TMO = 16;
  localparam int SMAX = 15;
  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] sel, rs_item, avail, sold, out_item;
  logic [31:0] balance, cost;
  logic rs_en, ack, cv, rej, fault, busy;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;
  int m_stock [N];
  bit m_active, m_done;
  int m_item, m_age;
  logic [N-1:0] m_out;
  logic [31:0] m_cost;
  bit m_cv, m_rej, m_fault;

  item_dispense_ctrl dut (
    .clk(clk), .reset_n(reset_n), .i_select_item(sel), .balance(balance),
    .i_restock_item(rs_item), .i_restock_en(rs_en), .i_dispense_ack(ack),
    .o_available_item(avail), .o_sold_out(sold), .o_output_item(out_item),
    .item_cost(cost), .o_cost_valid(cv), .o_reject(rej), .o_fault(fault), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] price_of(int k);
    return k == 0 ? 32'd400 : k == 1 ? 32'd500 : k == 2 ? 32'd1000 : 32'd2000;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      foreach (m_stock[k]) m_stock[k] = 10;
      m_active = 0; m_done = 0; m_out = '0; m_cost = '0;
      m_cv = 0; m_rej = 0; m_fault = 0;
    end else begin
      int dec_slot, found, s;
      dec_slot = -1;
      m_cv = 0; m_rej = 0; m_fault = 0; m_cost = '0;
      if (m_done) m_done = 0;
      else if (m_active) begin
        m_age++;
        if (ack) begin
          dec_slot = m_item; m_cv = 1; m_cost = price_of(m_item);
          m_active = 0; m_done = 1; m_out = '0;
        end else if (m_age == TMO) begin
          m_fault = 1; m_active = 0; m_out = '0;
        end
      end else if (sel != '0) begin
        found = -1;
        for (int k = N - 1; k >= 0; k--)
          if (sel[k] && m_stock[k] > 0 && price_of(k) <= balance) found = k;
        if (found < 0) m_rej = 1;
        else begin
          m_active = 1; m_item = found; m_age = 0; m_out = N'(1) << found;
        end
      end
      for (int k = 0; k < N; k++) begin
        s = m_stock[k] + ((rs_en && rs_item[k]) ? 1 : 0) - (k == dec_slot ? 1 : 0);
        m_stock[k] = s > SMAX ? SMAX : s;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    logic [N-1:0] e_av, e_so;
    for (int k = 0; k < N; k++) begin
      e_av[k] = m_stock[k] > 0 && price_of(k) <= balance;
      e_so[k] = m_stock[k] == 0;
      check($sformatf("stock%0d", k), 64'(dut.stock[k]), 64'(m_stock[k]));
    end
    check("output_item", 64'(out_item), 64'(m_out));
    check("item_cost", 64'(cost), 64'(m_cost));
    check("cost_valid", 64'(cv), 64'(m_cv));
    check("reject", 64'(rej), 64'(m_rej));
    check("fault", 64'(fault), 64'(m_fault));
    check("busy", 64'(busy), 64'(m_active || m_done));
    check("available", 64'(avail), 64'(e_av));
    check("sold_out", 64'(sold), 64'(e_so));
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic buy(logic [N-1:0] s, int wait_cycles);
    sel = s; tick; sel = '0;
    tick(wait_cycles);
    ack = 1'b1; tick; ack = 1'b0; tick;
  endtask

  initial begin
    reset_n = 1'b0; sel = '0; rs_item = '0; rs_en = 1'b0; ack = 1'b0; balance = '0;
    tick(2);
    reset_n = 1'b1; chk_en = 1;
    check("rst_out", 64'(out_item), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stock0", 64'(dut.stock[0]), 64'd10);
    balance = 32'd1000; sel = 4'b0001; tick;
    check("t1_onehot", 64'(out_item), 64'b0001);
    sel = '0; ack = 1'b1; tick; ack = 1'b0;
    check("t1_cv", 64'(cv), 64'd1);
    check("t1_cost", 64'(cost), 64'd400);
    check("t1_stock0", 64'(dut.stock[0]), 64'd9);
    tick;
    check("t1_idle", 64'(busy), 64'd0);
    balance = 32'd1500; sel = 4'b1110; tick;
    check("t2_onehot", 64'(out_item), 64'b0010);
    sel = '0; ack = 1'b1; tick; ack = 1'b0;
    check("t2_cost", 64'(cost), 64'd500);
    tick;
    balance = 32'd300; sel = 4'b0001; tick;
    check("t3_reject", 64'(rej), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    sel = '0; tick;
    check("t3_reject_off", 64'(rej), 64'd0);
    balance = 32'd2000; sel = 4'b1000; tick; sel = '0;
    tick(15);
    check("t4_pre_fault", 64'(fault), 64'd0);
    tick;
    check("t4_fault", 64'(fault), 64'd1);
    check("t4_no_cv", 64'(cv), 64'd0);
    check("t4_stock3", 64'(dut.stock[3]), 64'd10);
    tick;
    sel = 4'b1000; tick; sel = '0; tick(15);
    ack = 1'b1; tick; ack = 1'b0;
    check("t4_ack_wins", 64'(cv), 64'd1);
    check("t4_ack_nofault", 64'(fault), 64'd0);
    tick;
    rs_item = 4'b0010; tick;
    check("t5_no_en", 64'(dut.stock[1]), 64'd9);
    rs_item = '0;
    balance = 32'd1000;
    for (int i = 0; i < 9; i++) buy(4'b0001, i % 3);
    check("t5_sold_out", 64'(sold[0]), 64'd1);
    check("t5_not_avail", 64'(avail[0]), 64'd0);
    sel = 4'b0001; tick; sel = '0;
    check("t5_reject", 64'(rej), 64'd1);
    rs_item = 4'b0001; rs_en = 1'b1; tick(20);
    check("t5_saturate", 64'(dut.stock[0]), 64'd15);
    buy(4'b0001, 0);
    check("t5_inc_dec", 64'(dut.stock[0]), 64'd15);
    rs_en = 1'b0; rs_item = '0;
    sel = 4'b0100; tick; sel = '0;
    check("t6_onehot", 64'(out_item), 64'b0100);
    tick(3);
    reset_n = 1'b0; tick; reset_n = 1'b1;
    check("t6_rst_out", 64'(out_item), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_stock0", 64'(dut.stock[0]), 64'd10);
    ack = 1'b1; tick; ack = 1'b0;
    check("t6_late_ack", 64'(cv), 64'd0);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
